calendar_alarm_core: RTL and testbench

Parametrised successor to the lab 2 clock top level. It merges the following into one clocked core:
- the seconds-to-year calendar chain, with leap years;
- NA independent alarm channels, each with its own snooze/dismiss state machine;
- a 12/24-hour display conversion.

It runs from the 1 Hz pulse used as clock. Its binary outputs feed the existing `lcd_int` display drivers, so all seven-segment decoding stays outside the block.

---
 rtl/calendar_alarm_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_calendar_alarm_core.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_alarm_core.sv
// calendar_alarm_core: 1 Hz calendar chain (sec..year, leap years), NA alarm
// channels with independent snooze/dismiss FSMs, and 12/24-hour display
// conversion. Outputs are binary and feed the external lcd_int drivers.
module calendar_alarm_core #(
   parameter int NA         = 4,
   parameter int SNOOZE_MIN = 9,
   parameter int RING_MAX   = 60,
   localparam int SELW      = (NA > 1) ? $clog2(NA) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            timeset,
   input  logic            alarmset,
   input  logic [SELW-1:0] sel_alarm,
   input  logic            minadv,
   input  logic            hrsadv,
   input  logic            dayadv,
   input  logic            dateadv,
   input  logic            monthadv,
   input  logic            yearadv,
   input  logic [NA-1:0]   alarm_en,
   input  logic            snooze,
   input  logic            dismiss,
   input  logic            mode12,
   output logic [5:0]      sec,
   output logic [5:0]      min,
   output logic [4:0]      hrs,
   output logic [4:0]      hrs_disp,
   output logic            pm,
   output logic [2:0]      day,
   output logic [4:0]      date,
   output logic [3:0]      month,
   output logic [6:0]      year,
   output logic            buzz,
   output logic [NA-1:0]   buzz_ch,
   output logic [5:0]      amin_q,
   output logic [4:0]      ahrs_q
);

   localparam int SNZ_CYC  = SNOOZE_MIN * 60;
   localparam int SNZW     = $clog2(SNZ_CYC);
   localparam int RINGW    = 8;

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

   // Year 0 counts as leap, so year[1:0]==0 is the whole leap rule for 0..99.
   function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 return 5'd31;
      endcase
   endfunction

   logic [5:0]   sec_n, min_n;
   logic [4:0]   hrs_n, date_n, dim_n;
   logic [2:0]   day_n;
   logic [3:0]   month_n;
   logic [6:0]   year_n;

   logic [5:0]   amin [NA];
   logic [4:0]   ahrs [NA];

   alarm_state_t st     [NA];
   alarm_state_t st_n   [NA];
   logic [SNZW-1:0]  snz_ct   [NA];
   logic [SNZW-1:0]  snz_ct_n [NA];
   logic [RINGW-1:0] ring_ct  [NA];
   logic [RINGW-1:0] ring_ct_n[NA];

   // Next calendar value: full carry chain when running, per-field wrap when setting.
   // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      sec_n   = sec;
      min_n   = min;
      hrs_n   = hrs;
      day_n   = day;
      date_n  = date;
      month_n = month;
      year_n  = year;
      dim_n   = 5'd31;
      if (timeset) begin
         if (minadv)   min_n   = (min   == 6'd59) ? 6'd0 : min   + 6'd1;
         if (hrsadv)   hrs_n   = (hrs   == 5'd23) ? 5'd0 : hrs   + 5'd1;
         if (dayadv)   day_n   = (day   == 3'd6)  ? 3'd0 : day   + 3'd1;
         if (monthadv) month_n = (month == 4'd12) ? 4'd1 : month + 4'd1;
         if (yearadv)  year_n  = (year  == 7'd99) ? 7'd0 : year  + 7'd1;
         // Date limits follow the month/year being written on this same edge.
         dim_n = days_in_month(month_n, year_n);
         if (dateadv)
            date_n = (date >= dim_n) ? 5'd1 : date + 5'd1;
         else if (date > dim_n)
            date_n = dim_n;
      end else begin
         sec_n = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
         if (sec == 6'd59) begin
            min_n = (min == 6'd59) ? 6'd0 : min + 6'd1;
            if (min == 6'd59) begin
               hrs_n = (hrs == 5'd23) ? 5'd0 : hrs + 5'd1;
               if (hrs == 5'd23) begin
                  day_n = (day == 3'd6) ? 3'd0 : day + 3'd1;
                  if (date >= days_in_month(month, year)) begin
                     date_n = 5'd1;
                     month_n = (month == 4'd12) ? 4'd1 : month + 4'd1;
                     if (month == 4'd12)
                        year_n = (year == 7'd99) ? 7'd0 : year + 7'd1;
                  end else begin
                     date_n = date + 5'd1;
                  end
               end
            end
         end
      end
   end

   // Calendar registers.
   // NOTE: clocked state uses non-blocking '<=' so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sec   <= 6'd0;
         min   <= 6'd0;
         hrs   <= 5'd0;
         day   <= 3'd0;
         date  <= 5'd1;
         month <= 4'd1;
         year  <= 7'd0;
      end else begin
         sec   <= sec_n;
         min   <= min_n;
         hrs   <= hrs_n;
         day   <= day_n;
         date  <= date_n;
         month <= month_n;
         year  <= year_n;
      end
   end

   // Alarm time registers, stepped for the selected channel while in alarm-set mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the alarm-time array is a few flops with a defined power-up value, so it is reset like any register.
         for (int i = 0; i < NA; i++) begin
            amin[i] <= 6'd0;
            ahrs[i] <= 5'd0;
         end
      end else if (alarmset && !timeset) begin
         for (int i = 0; i < NA; i++) begin
            if (sel_alarm == SELW'(i)) begin
               if (minadv) amin[i] <= (amin[i] == 6'd59) ? 6'd0 : amin[i] + 6'd1;
               if (hrsadv) ahrs[i] <= (ahrs[i] == 5'd23) ? 5'd0 : ahrs[i] + 5'd1;
            end
         end
      end
   end

   // Read back the alarm time of the addressed channel for display.
   always_comb begin
      amin_q = 6'd0;
      ahrs_q = 5'd0;
      for (int i = 0; i < NA; i++) begin
         if (sel_alarm == SELW'(i)) begin
            amin_q = amin[i];
            ahrs_q = ahrs[i];
         end
      end
   end

   // Per-channel next state: disarm > dismiss > snooze > timers/trigger.
   always_comb begin
      for (int i = 0; i < NA; i++) begin
         st_n[i]      = st[i];
         snz_ct_n[i]  = snz_ct[i];
         ring_ct_n[i] = ring_ct[i];
         if (!alarm_en[i]) begin
            st_n[i]      = IDLE;
            snz_ct_n[i]  = '0;
            ring_ct_n[i] = '0;
         end else begin
            case (st[i])
               IDLE: begin
                  if (!dismiss && !timeset && sec == 6'd0 &&
                      min == amin[i] && hrs == ahrs[i]) begin
                     st_n[i]      = RINGING;
                     ring_ct_n[i] = '0;
                  end
               end
               RINGING: begin
                  if (dismiss) begin
                     st_n[i] = IDLE;
                  end else if (snooze) begin
                     st_n[i]     = SNOOZED;
                     snz_ct_n[i] = SNZW'(SNZ_CYC - 1);
                  end else if (ring_ct[i] == RINGW'(RING_MAX - 1)) begin
                     st_n[i] = IDLE;
                  end else begin
                     ring_ct_n[i] = ring_ct[i] + RINGW'(1);
                  end
               end
               SNOOZED: begin
                  if (dismiss) begin
                     st_n[i] = IDLE;
                  end else if (snz_ct[i] == '0) begin
                     st_n[i]      = RINGING;
                     ring_ct_n[i] = '0;
                  end else begin
                     snz_ct_n[i] = snz_ct[i] - SNZW'(1);
                  end
               end
               default: st_n[i] = IDLE;
            endcase
         end
      end
   end

   // Channel state, counters and the registered ringing flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NA; i++) begin
            st[i]      <= IDLE;
            snz_ct[i]  <= '0;
            ring_ct[i] <= '0;
         end
         buzz_ch <= '0;
      end else begin
         for (int i = 0; i < NA; i++) begin
            st[i]      <= st_n[i];
            snz_ct[i]  <= snz_ct_n[i];
            ring_ct[i] <= ring_ct_n[i];
            buzz_ch[i] <= (st_n[i] == RINGING);
         end
      end
   end

   assign buzz = |buzz_ch;
   assign pm   = (hrs >= 5'd12);

   // 12-hour view: midnight shows 12, afternoon hours fold down by 12.
   always_comb begin
      hrs_disp = hrs;
      if (mode12) begin
         if (hrs == 5'd0)
            hrs_disp = 5'd12;
         else if (hrs > 5'd12)
            hrs_disp = hrs - 5'd12;
      end
   end

endmodule

// File: tb/tb_calendar_alarm_core.sv
// Testbench for calendar_alarm_core: calendar rollover, leap years, date
// clamping, alarm fire/timeout, snooze, multi-channel, reset and 12-hour view.
module tb_calendar_alarm_core;

   logic       clk = 1'b0;
   logic       rst, timeset, alarmset;
   logic [1:0] sel_alarm;
   logic       minadv, hrsadv, dayadv, dateadv, monthadv, yearadv;
   logic [3:0] alarm_en;
   logic       snooze, dismiss, mode12;
   logic [5:0] sec, min, amin_q;
   logic [4:0] hrs, hrs_disp, date, ahrs_q;
   logic       pm, buzz;
   logic [2:0] day;
   logic [3:0] month, buzz_ch;
   logic [6:0] year;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   calendar_alarm_core #(.NA(4), .SNOOZE_MIN(9), .RING_MAX(60)) dut (
      .clk(clk), .rst(rst), .timeset(timeset), .alarmset(alarmset),
      .sel_alarm(sel_alarm), .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv),
      .dateadv(dateadv), .monthadv(monthadv), .yearadv(yearadv),
      .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss), .mode12(mode12),
      .sec(sec), .min(min), .hrs(hrs), .hrs_disp(hrs_disp), .pm(pm), .day(day),
      .date(date), .month(month), .year(year), .buzz(buzz), .buzz_ch(buzz_ch),
      .amin_q(amin_q), .ahrs_q(ahrs_q)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk(input int s, input int m, input int h, input int d,
                                      input int dt, input int mo, input int y,
                                      input logic [3:0] bc);
      return 64'({6'(s), 6'(m), 5'(h), 3'(d), 5'(dt), 4'(mo), 7'(y), |bc, bc});
   endfunction

   function automatic logic [63:0] snap_now();
      return 64'({sec, min, hrs, day, date, month, year, buzz, buzz_ch});
   endfunction

   function automatic void push(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      timeset = 0; alarmset = 0; sel_alarm = 0;
      minadv = 0; hrsadv = 0; dayadv = 0; dateadv = 0; monthadv = 0; yearadv = 0;
      alarm_en = 0; snooze = 0; dismiss = 0; mode12 = 0;
      rst = 1;
      tick();
      rst = 0;
   endtask

   // Hold timeset and press each field's button the given number of cycles.
   task automatic advance_fields(input int n_min, input int n_hrs, input int n_day,
                                 input int n_date, input int n_month, input int n_year);
      timeset = 1;
      for (int j = 0; j < 60; j++) begin
         minadv   = (j < n_min);
         hrsadv   = (j < n_hrs);
         dayadv   = (j < n_day);
         dateadv  = (j < n_date);
         monthadv = (j < n_month);
         yearadv  = (j < n_year);
         tick();
      end
      minadv = 0; hrsadv = 0; dayadv = 0; dateadv = 0; monthadv = 0; yearadv = 0;
      timeset = 0;
   endtask

   // Reset, set every channel in mask to 07:30, then bring the clock to 07:30:00.
   task automatic arm_0730(input logic [3:0] mask);
      int elapsed;
      elapsed = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            alarmset  = 1;
            sel_alarm = 2'(i);
            for (int j = 0; j < 30; j++) begin
               hrsadv = (j < 7);
               minadv = 1;
               tick();
            end
            hrsadv = 0; minadv = 0; alarmset = 0;
            elapsed += 30;
         end
      end
      sel_alarm = 0;
      timeset = 1;
      for (int j = 0; j < 29; j++) begin
         minadv = (j < 29 - elapsed / 60);
         hrsadv = (j < 7);
         tick();
      end
      minadv = 0; hrsadv = 0; timeset = 0;
      alarm_en = mask;
      run(60 - elapsed % 60);
   endtask

   task automatic test_reset();
      exp_t e;
      do_reset();
      push("reset_state", mk(0, 0, 0, 0, 1, 1, 0, 4'b0000));
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("reset_disp", 64'({5'd0, 1'b0}));
      e = sb.pop_front(); total++;
      if (64'({hrs_disp, pm}) !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, 64'({hrs_disp, pm}), e.val);
      end
   endtask

   task automatic test_rollover();
      exp_t e;
      do_reset();
      advance_fields(59, 23, 2, 30, 11, 3);
      run(59);
      push("preset_dec31", mk(59, 59, 23, 2, 31, 12, 3, 4'b0000));
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("new_year", mk(0, 0, 0, 3, 1, 1, 4, 4'b0000));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
   endtask

   task automatic test_leap();
      exp_t e;
      do_reset();
      advance_fields(59, 23, 0, 27, 1, 1);
      run(59);
      push("feb28_y1_to_mar1", mk(0, 0, 0, 1, 1, 3, 1, 4'b0000));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      do_reset();
      advance_fields(59, 23, 0, 27, 1, 4);
      run(59);
      push("feb28_y4_to_feb29", mk(0, 0, 0, 1, 29, 2, 4, 4'b0000));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      do_reset();
      advance_fields(0, 0, 0, 30, 0, 1);
      push("preset_jan31_y1", mk(0, 0, 0, 0, 31, 1, 1, 4'b0000));
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      timeset = 1; monthadv = 1;
      push("clamp_feb28", mk(0, 0, 0, 0, 28, 2, 1, 4'b0000));
      tick();
      monthadv = 0; timeset = 0;
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
   endtask

   task automatic test_alarm_fire();
      exp_t e;
      arm_0730(4'b0100);
      push("at_0730_00", mk(0, 30, 7, 0, 1, 1, 0, 4'b0000));
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      sel_alarm = 2'd2; #1;
      push("alarm_q_ch2", 64'({6'd30, 5'd7}));
      e = sb.pop_front(); total++;
      if (64'({amin_q, ahrs_q}) !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, 64'({amin_q, ahrs_q}), e.val);
      end
      sel_alarm = 2'd0; #1;
      push("alarm_q_ch0", 64'({6'd0, 5'd0}));
      e = sb.pop_front(); total++;
      if (64'({amin_q, ahrs_q}) !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, 64'({amin_q, ahrs_q}), e.val);
      end
      push("ring_start", mk(1, 30, 7, 0, 1, 1, 0, 4'b0100));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("ring_last", mk(0, 31, 7, 0, 1, 1, 0, 4'b0100));
      run(59);
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("ring_timeout", mk(1, 31, 7, 0, 1, 1, 0, 4'b0000));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
   endtask

   task automatic test_snooze();
      exp_t e;
      arm_0730(4'b0100);
      run(4);
      snooze = 1;
      push("snooze_low_first", mk(5, 30, 7, 0, 1, 1, 0, 4'b0000));
      tick();
      snooze = 0;
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("snooze_low_last", mk(4, 39, 7, 0, 1, 1, 0, 4'b0000));
      run(539);
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("re_ring", mk(5, 39, 7, 0, 1, 1, 0, 4'b0100));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      dismiss = 1;
      push("dismissed", mk(6, 39, 7, 0, 1, 1, 0, 4'b0000));
      tick();
      dismiss = 0;
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("no_retrigger", mk(6, 41, 7, 0, 1, 1, 0, 4'b0000));
      run(120);
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
   endtask

   task automatic test_multi_channel();
      exp_t e;
      arm_0730(4'b1001);
      push("multi_at_0730", mk(0, 30, 7, 0, 1, 1, 0, 4'b0000));
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      push("multi_ring", mk(1, 30, 7, 0, 1, 1, 0, 4'b1001));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      dismiss = 1;
      push("multi_dismiss", mk(2, 30, 7, 0, 1, 1, 0, 4'b0000));
      tick();
      dismiss = 0;
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      arm_0730(4'b1001);
      tick();
      alarm_en = 4'b0001;
      push("disarm_ch3", mk(2, 30, 7, 0, 1, 1, 0, 4'b0001));
      tick();
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
      rst = 1;
      push("reset_mid_ring", mk(0, 0, 0, 0, 1, 1, 0, 4'b0000));
      tick();
      rst = 0;
      alarm_en = 0;
      e = sb.pop_front(); total++;
      if (snap_now() !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, snap_now(), e.val);
      end
   endtask

   task automatic test_mode12();
      exp_t e;
      do_reset();
      mode12 = 1; #1;
      push("h0_mode12", 64'({5'd12, 1'b0}));
      e = sb.pop_front(); total++;
      if (64'({hrs_disp, pm}) !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, 64'({hrs_disp, pm}), e.val);
      end
      timeset = 1; hrsadv = 1;
      run(12);
      push("h12_mode12", 64'({5'd12, 1'b1}));
      e = sb.pop_front(); total++;
      if (64'({hrs_disp, pm}) !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, 64'({hrs_disp, pm}), e.val);
      end
      tick();
      hrsadv = 0;
      push("h13_mode12", 64'({5'd1, 1'b1}));
      e = sb.pop_front(); total++;
      if (64'({hrs_disp, pm}) !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, 64'({hrs_disp, pm}), e.val);
      end
      mode12 = 0; #1;
      push("h13_mode24", 64'({5'd13, 1'b1}));
      e = sb.pop_front(); total++;
      if (64'({hrs_disp, pm}) !== e.val) begin
         bad++; $display("FAIL %s: got %h expected %h", e.tag, 64'({hrs_disp, pm}), e.val);
      end
      timeset = 0;
   endtask

   initial begin
      test_reset();
      test_rollover();
      test_leap();
      test_alarm_fire();
      test_snooze();
      test_multi_channel();
      test_mode12();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
